// File: rtl/outer_source.sv
// Single-word DDR3-style command sequencer: fixed init, then button-driven write/read of one location.
// Optional periodic refresh is built when REFRESH_EN is defined.
module outer_source #(
    parameter int unsigned T_RST = 4,
    parameter int unsigned T_CKE = 4,
    parameter int unsigned T_RCD = 2,
    parameter int unsigned CWL   = 2,
    parameter int unsigned CL    = 3,
    parameter int unsigned T_RP  = 2,
    parameter logic [14:0] ROW   = 15'd0,
    parameter logic [14:0] COL   = 15'd0,
    parameter logic [2:0]  BANK  = 3'd0
) (
    input  logic        sysclk_p,
    input  logic        sysclk_n,
    input  logic        RESET_SM_button,
    input  logic        btnl,
    input  logic        btnr,
    input  logic [7:0]  switch,
    inout  wire  [15:0] DQ,
    inout  wire         LDQS,
    inout  wire         LDQS_n,
    inout  wire         UDQS,
    inout  wire         UDQS_n,
    output logic        CS,
    output logic        RAS,
    output logic        CAS,
    output logic        WE,
    output logic        RESET_DRAM,
    output logic [14:0] Addr_out,
    output logic [2:0]  BA_out,
    output logic        LDM,
    output logic        UDM,
    output logic [7:0]  led,
    output logic        CK,
    output logic        CK_n,
    output logic        CKE
);

    typedef enum logic [3:0] {
        StInitRst, StInitCke, StIdle, StAct, StWaitRcd,
        StWrCmd, StWrWait, StWrData, StRdCmd, StRdWait, StRdCap,
        StPre, StWaitRp, StRef, StRefWait
    } state_e;

    localparam logic [3:0] CmdNop = 4'b0111;
    localparam logic [3:0] CmdAct = 4'b0011;
    localparam logic [3:0] CmdWr  = 4'b0100;
    localparam logic [3:0] CmdRd  = 4'b0101;
    localparam logic [3:0] CmdPre = 4'b0010;
`ifdef REFRESH_EN
    localparam logic [3:0] CmdRef = 4'b0001;
`endif

    localparam logic [3:0] CntRst = 4'(T_RST - 1);
    localparam logic [3:0] CntCke = 4'(T_CKE - 1);
    localparam logic [3:0] CntRcd = 4'(T_RCD - 1);
    localparam logic [3:0] CntCwl = 4'(CWL - 1);
    localparam logic [3:0] CntCl  = 4'(CL - 1);
    localparam logic [3:0] CntRp  = 4'(T_RP - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        op_wr_q;
    logic [7:0]  wr_byte_q;
    logic [7:0]  led_q;
    // [0],[1] synchronizer stages, [2] previous synchronized value for edge detect
    logic [2:0]  btnl_sync_q, btnr_sync_q;
    logic        wr_edge, rd_edge, wr_req, rd_req;
    logic [3:0]  cmd;
    logic        dq_oe, dqs;

    assign wr_edge = btnl_sync_q[1] & ~btnl_sync_q[2];
    assign rd_edge = btnr_sync_q[1] & ~btnr_sync_q[2];

`ifdef REFRESH_EN
    logic [5:0] idle_cnt_q;
    logic       wr_pend_q, rd_pend_q;
    logic       in_refresh;

    assign in_refresh = (state_q == StRef) || (state_q == StRefWait);
    assign wr_req     = wr_edge | wr_pend_q;
    assign rd_req     = rd_edge | rd_pend_q;

    always_ff @(posedge sysclk_p or negedge RESET_SM_button) begin
        if (!RESET_SM_button) begin
            idle_cnt_q <= '0;
            wr_pend_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
        end else begin
            if (state_q == StIdle && !wr_req && !rd_req) begin
                idle_cnt_q <= idle_cnt_q + 6'd1;
            end else begin
                idle_cnt_q <= '0;
            end
            if (state_q == StIdle) begin
                wr_pend_q <= 1'b0;
                rd_pend_q <= 1'b0;
            end else if (in_refresh) begin
                wr_pend_q <= wr_pend_q | wr_edge;
                rd_pend_q <= rd_pend_q | rd_edge;
            end
        end
    end
`else
    assign wr_req = wr_edge;
    assign rd_req = rd_edge;
`endif

    always_ff @(posedge sysclk_p or negedge RESET_SM_button) begin
        if (!RESET_SM_button) begin
            state_q     <= StInitRst;
            cnt_q       <= CntRst;
            op_wr_q     <= 1'b0;
            wr_byte_q   <= '0;
            led_q       <= '0;
            btnl_sync_q <= '0;
            btnr_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            btnl_sync_q <= {btnl_sync_q[1:0], btnl};
            btnr_sync_q <= {btnr_sync_q[1:0], btnr};
            if (state_q == StIdle) begin
                op_wr_q <= wr_req;
                if (wr_req) begin
                    wr_byte_q <= switch;
                end
            end
            if (state_q == StRdCap) begin
                led_q <= DQ[7:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
        case (state_q)
            StInitRst: if (cnt_q == 4'd0) begin
                state_d = StInitCke;
                cnt_d   = CntCke;
            end
            StInitCke: if (cnt_q == 4'd0) state_d = StIdle;
            StIdle: begin
                if (wr_req || rd_req) begin
                    state_d = StAct;
`ifdef REFRESH_EN
                end else if (idle_cnt_q == 6'd63) begin
                    state_d = StRef;
`endif
                end
            end
            StAct: begin
                state_d = StWaitRcd;
                cnt_d   = CntRcd;
            end
            StWaitRcd: if (cnt_q == 4'd0) state_d = op_wr_q ? StWrCmd : StRdCmd;
            StWrCmd: begin
                state_d = StWrWait;
                cnt_d   = CntCwl;
            end
            StWrWait: if (cnt_q == 4'd0) begin
                state_d = StWrData;
                cnt_d   = 4'd1;
            end
            StWrData: if (cnt_q == 4'd0) state_d = StPre;
            StRdCmd: begin
                state_d = StRdWait;
                cnt_d   = CntCl;
            end
            StRdWait: if (cnt_q == 4'd0) state_d = StRdCap;
            StRdCap: state_d = StPre;
            StPre: begin
                state_d = StWaitRp;
                cnt_d   = CntRp;
            end
            StWaitRp: if (cnt_q == 4'd0) state_d = StIdle;
`ifdef REFRESH_EN
            StRef: begin
                state_d = StRefWait;
                cnt_d   = 4'd7;
            end
            StRefWait: if (cnt_q == 4'd0) state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd      = CmdNop;
        Addr_out = '0;
        BA_out   = '0;
        case (state_q)
            StAct: begin
                cmd      = CmdAct;
                Addr_out = ROW;
                BA_out   = BANK;
            end
            StWrCmd: begin
                cmd      = CmdWr;
                Addr_out = {COL[14:11], 1'b0, COL[9:0]};
                BA_out   = BANK;
            end
            StRdCmd: begin
                cmd      = CmdRd;
                Addr_out = {COL[14:11], 1'b0, COL[9:0]};
                BA_out   = BANK;
            end
            StPre: cmd = CmdPre;
`ifdef REFRESH_EN
            StRef: cmd = CmdRef;
`endif
            default: cmd = CmdNop;
        endcase
    end

    // Command pins are deselected for as long as the reset button is held.
    assign {CS, RAS, CAS, WE} = RESET_SM_button ? cmd : 4'b1111;
    assign RESET_DRAM = (state_q != StInitRst);
    assign CKE        = (state_q != StInitRst) && (state_q != StInitCke);

    // Write burst: strobe high in the first data cycle (cnt_q == 1), low in the second.
    assign dq_oe  = (state_q == StWrData);
    assign dqs    = cnt_q[0];
    assign DQ     = dq_oe ? {8'h00, wr_byte_q} : 16'hzzzz;
    assign LDQS   = dq_oe ? dqs  : 1'bz;
    assign LDQS_n = dq_oe ? ~dqs : 1'bz;
    assign UDQS   = dq_oe ? dqs  : 1'bz;
    assign UDQS_n = dq_oe ? ~dqs : 1'bz;
    assign LDM    = 1'b0;
    assign UDM    = dq_oe;

    assign led  = led_q;
    assign CK   = sysclk_p;
    assign CK_n = ~sysclk_p;

    logic unused_inputs;
    assign unused_inputs = ^{sysclk_n, DQ[15:8], LDQS, LDQS_n, UDQS, UDQS_n};

endmodule

// File: tb/tb_outer_source.sv
// Directed bench for outer_source: reset/init timing, write, read, collision, busy drop, mid-op reset.
module tb_outer_source;

    logic        sysclk_p = 1'b0;
    logic        sysclk_n;
    logic        RESET_SM_button;
    logic        btnl, btnr;
    logic [7:0]  switch;
    tri1  [15:0] DQ;
    tri1         LDQS, LDQS_n, UDQS, UDQS_n;
    wire         CS, RAS, CAS, WE, RESET_DRAM, LDM, UDM, CK, CK_n, CKE;
    wire  [14:0] Addr_out;
    wire  [2:0]  BA_out;
    wire  [7:0]  led;

    logic [15:0] tb_dq;
    logic        tb_dq_oe;
    int          checks = 0;
    int          errors = 0;
    int          busy_cmds;

    // Undriven pins float to all-ones through the tri1 nets, so 16'hFFFF means high-Z.
    assign DQ = tb_dq_oe ? tb_dq : 16'hzzzz;

    always #5 sysclk_p = ~sysclk_p;
    assign sysclk_n = ~sysclk_p;

    outer_source dut (
        .sysclk_p        (sysclk_p),
        .sysclk_n        (sysclk_n),
        .RESET_SM_button (RESET_SM_button),
        .btnl            (btnl),
        .btnr            (btnr),
        .switch          (switch),
        .DQ              (DQ),
        .LDQS            (LDQS),
        .LDQS_n          (LDQS_n),
        .UDQS            (UDQS),
        .UDQS_n          (UDQS_n),
        .CS              (CS),
        .RAS             (RAS),
        .CAS             (CAS),
        .WE              (WE),
        .RESET_DRAM      (RESET_DRAM),
        .Addr_out        (Addr_out),
        .BA_out          (BA_out),
        .LDM             (LDM),
        .UDM             (UDM),
        .led             (led),
        .CK              (CK),
        .CK_n            (CK_n),
        .CKE             (CKE)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sysclk_p);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] cmd_now();
        return {12'd0, CS, RAS, CAS, WE};
    endfunction

    initial begin
        RESET_SM_button = 1'b0;
        btnl = 1'b0;
        btnr = 1'b0;
        switch = 8'h00;
        tb_dq = 16'h0000;
        tb_dq_oe = 1'b0;

        // Reset held
        tick(5);
        check("rst_cmd", cmd_now(), 16'h000F);
        check("rst_reset_dram", {15'd0, RESET_DRAM}, 16'd0);
        check("rst_cke", {15'd0, CKE}, 16'd0);
        check("rst_led", {8'd0, led}, 16'd0);
        check("rst_dq_z", DQ, 16'hFFFF);
        check("rst_ldqs_n_z", {15'd0, LDQS_n}, 16'd1);
        check("rst_masks", {14'd0, LDM, UDM}, 16'd0);
        check("rst_addr", {1'b0, Addr_out}, 16'd0);

        // Init timing
        RESET_SM_button = 1'b1;
        tick(3);
        check("init_rst_hold", {15'd0, RESET_DRAM}, 16'd0);
        check("init_nop", cmd_now(), 16'h0007);
        tick(1);
        check("init_rst_rise", {15'd0, RESET_DRAM}, 16'd1);
        check("init_cke_low", {15'd0, CKE}, 16'd0);
        tick(3);
        check("init_cke_hold", {15'd0, CKE}, 16'd0);
        tick(1);
        check("init_cke_rise", {15'd0, CKE}, 16'd1);
        check("idle_nop", cmd_now(), 16'h0007);

        // Write 0xAA; switch changes after the request is taken
        switch = 8'hAA;
        btnl = 1'b1;
        tick(1);
        btnl = 1'b0;
        tick(2);
        check("wr_act", cmd_now(), 16'h0003);
        check("wr_act_addr", {1'b0, Addr_out}, 16'd0);
        check("wr_act_ba", {13'd0, BA_out}, 16'd0);
        switch = 8'h55;
        tick(1);
        check("wr_rcd_nop", cmd_now(), 16'h0007);
        tick(2);
        check("wr_cmd", cmd_now(), 16'h0004);
        check("wr_cmd_addr", {1'b0, Addr_out}, 16'd0);
        tick(1);
        check("wr_wait_dq_z", DQ, 16'hFFFF);
        tick(2);
        check("wr_d1_dq", DQ, 16'h00AA);
        check("wr_d1_strobes", {12'd0, LDQS, LDQS_n, UDQS, UDQS_n}, 16'b1010);
        check("wr_d1_masks", {14'd0, LDM, UDM}, 16'b01);
        tick(1);
        check("wr_d2_dq", DQ, 16'h00AA);
        check("wr_d2_strobes", {12'd0, LDQS, LDQS_n, UDQS, UDQS_n}, 16'b0101);
        tick(1);
        check("wr_pre", cmd_now(), 16'h0002);
        check("wr_pre_dq_z", DQ, 16'hFFFF);
        check("wr_pre_udm", {15'd0, UDM}, 16'd0);
        tick(3);
        check("wr_back_idle", cmd_now(), 16'h0007);

        // Read; bench DRAM model drives 0x00F0 during the capture cycle
        btnr = 1'b1;
        tick(1);
        btnr = 1'b0;
        tick(2);
        check("rd_act", cmd_now(), 16'h0003);
        tick(3);
        check("rd_cmd", cmd_now(), 16'h0005);
        check("rd_cmd_ba", {13'd0, BA_out}, 16'd0);
        tick(3);
        check("rd_wait_nop", cmd_now(), 16'h0007);
        tick(1);
        tb_dq = 16'h00F0;
        tb_dq_oe = 1'b1;
        check("rd_cap_led_old", {8'd0, led}, 16'h0000);
        tick(1);
        tb_dq_oe = 1'b0;
        check("rd_led", {8'd0, led}, 16'h00F0);
        check("rd_pre", cmd_now(), 16'h0002);
        tick(3);
        check("rd_back_idle", cmd_now(), 16'h0007);

        // Collision: write wins, read dropped
        switch = 8'h3C;
        btnl = 1'b1;
        btnr = 1'b1;
        tick(1);
        btnl = 1'b0;
        btnr = 1'b0;
        tick(2);
        check("col_act", cmd_now(), 16'h0003);
        tick(3);
        check("col_is_write", cmd_now(), 16'h0004);
        tick(3);
        check("col_dq", DQ, 16'h003C);
        tick(5);
        check("col_idle", cmd_now(), 16'h0007);
        busy_cmds = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (cmd_now() != 16'h0007) busy_cmds++;
        end
        check("col_no_read", 16'(busy_cmds), 16'd0);

        // Busy drop: read request during WR_WAIT is ignored
        switch = 8'h11;
        btnl = 1'b1;
        tick(1);
        btnl = 1'b0;
        tick(2);
        check("busy_act", cmd_now(), 16'h0003);
        tick(4);
        btnr = 1'b1;
        tick(1);
        btnr = 1'b0;
        tick(6);
        check("busy_idle", cmd_now(), 16'h0007);
        busy_cmds = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (cmd_now() != 16'h0007) busy_cmds++;
        end
        check("busy_no_read", 16'(busy_cmds), 16'd0);
        check("busy_led_kept", {8'd0, led}, 16'h00F0);

        // Reset in the middle of WR_DATA
        switch = 8'h99;
        btnl = 1'b1;
        tick(1);
        btnl = 1'b0;
        tick(2);
        check("mid_act", cmd_now(), 16'h0003);
        tick(6);
        check("mid_wr_dq", DQ, 16'h0099);
        #2;
        RESET_SM_button = 1'b0;
        #1;
        check("mid_dq_z", DQ, 16'hFFFF);
        check("mid_cmd", cmd_now(), 16'h000F);
        check("mid_reset_dram", {15'd0, RESET_DRAM}, 16'd0);
        check("mid_cke", {15'd0, CKE}, 16'd0);
        check("mid_led", {8'd0, led}, 16'h0000);
        check("mid_strobe_z", {14'd0, LDQS_n, UDQS_n}, 16'b11);
        tick(2);
        RESET_SM_button = 1'b1;
        tick(3);
        check("mid_init_hold", {15'd0, RESET_DRAM}, 16'd0);
        check("mid_init_nop", cmd_now(), 16'h0007);
        tick(1);
        check("mid_init_rise", {15'd0, RESET_DRAM}, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
